// File: rtl/matvec_mac_sequencer.sv
// Matrix-by-vector product C = A*B sequenced through one shared multiply-accumulate unit.
// Optional stall counter output perf_stall is enabled by defining MATVEC_PERF_EN.
module matvec_mac_sequencer #(
   parameter int N      = 4,
   parameter int DATA_W = 7,
   parameter int ACC_W  = 18,
   parameter int ADDR_W = 4,
   localparam int ROW_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ld_en,
   input  logic              ld_sel,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [DATA_W-1:0] ld_data,
   output logic              ld_err,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ROW_W-1:0]  out_row,
   output logic [ACC_W-1:0]  out_data
`ifdef MATVEC_PERF_EN
   ,
   output logic [15:0]       perf_stall
`endif
);

   localparam int IDX_W = (N > 1) ? $clog2(N * N) : 1;
   localparam logic [ROW_W-1:0] LAST    = ROW_W'(N - 1);
   localparam logic [ADDR_W:0]  A_DEPTH = (ADDR_W + 1)'(N * N);
   localparam logic [ADDR_W:0]  B_DEPTH = (ADDR_W + 1)'(N);

   typedef enum logic [1:0] {IDLE, MAC, EMIT, DONE} state_t;

   state_t state, state_nxt;

   logic [DATA_W-1:0]   a_mem [N*N];
   logic [DATA_W-1:0]   b_mem [N];
   logic [ROW_W-1:0]    row, col;
   logic [ACC_W-1:0]    acc;
   logic                addr_ok, wr_ok;
   logic [IDX_W-1:0]    a_idx;
   logic [2*DATA_W-1:0] prod;
   logic [ACC_W-1:0]    prod_ext;

   assign busy      = (state != IDLE);
   assign out_valid = (state == EMIT);
   assign done      = (state == DONE);
   assign out_row   = row;
   assign out_data  = acc;

   assign addr_ok = ld_sel ? ({1'b0, ld_addr} < B_DEPTH) : ({1'b0, ld_addr} < A_DEPTH);
   assign wr_ok   = ld_en & ~busy & addr_ok;

   assign a_idx    = IDX_W'(int'(row) * N + int'(col));
   assign prod     = {{DATA_W{1'b0}}, a_mem[a_idx]} * {{DATA_W{1'b0}}, b_mem[col]};
   assign prod_ext = ACC_W'(prod);

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // NOTE: the default assignment first means every path drives state_nxt, so no latch is inferred.
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (start) state_nxt = MAC;
         MAC:     if (col == LAST) state_nxt = EMIT;
         EMIT:    if (out_ready) state_nxt = (row == LAST) ? DONE : MAC;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: non-blocking assignments here so every register samples pre-edge values, including acc reading col.
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: storage is cleared on reset on purpose; this makes it a register file, not an inferable RAM.
         for (int i = 0; i < N * N; i++) a_mem[i] <= '0;
         for (int i = 0; i < N; i++)     b_mem[i] <= '0;
         ld_err <= 1'b0;
         acc    <= '0;
         row    <= '0;
         col    <= '0;
      end else begin
         ld_err <= ld_en & (busy | ~addr_ok);
         if (wr_ok) begin
            if (ld_sel) b_mem[ld_addr[ROW_W-1:0]] <= ld_data;
            else        a_mem[ld_addr[IDX_W-1:0]] <= ld_data;
         end
         unique case (state)
            IDLE: begin
               if (start) begin
                  row <= '0;
                  col <= '0;
               end
            end
            MAC: begin
               acc <= (col == '0) ? prod_ext : acc + prod_ext;
               col <= (col == LAST) ? '0 : col + ROW_W'(1);
            end
            EMIT: begin
               if (out_ready && row != LAST) row <= row + ROW_W'(1);
            end
            default: ;
         endcase
      end
   end

`ifdef MATVEC_PERF_EN
   always_ff @(posedge clk) begin
      if (rst)                                   perf_stall <= '0;
      else if (state == IDLE && start)           perf_stall <= '0;
      else if (out_valid && !out_ready && perf_stall != 16'hFFFF)
                                                 perf_stall <= perf_stall + 16'd1;
   end
`endif

endmodule

// File: tb/tb_matvec_mac_sequencer.sv
// Scoreboard bench for matvec_mac_sequencer: stimulus pushes expected row results, a monitor pops and compares.
module tb_matvec_mac_sequencer;

   localparam int N = 4, DATA_W = 7, ACC_W = 18, ADDR_W = 4, ROW_W = 2;

   logic              clk = 1'b0;
   logic              rst, ld_en, ld_sel, start, out_ready;
   logic [ADDR_W-1:0] ld_addr;
   logic [DATA_W-1:0] ld_data;
   logic              ld_err, busy, done, out_valid;
   logic [ROW_W-1:0]  out_row;
   logic [ACC_W-1:0]  out_data;
`ifdef MATVEC_PERF_EN
   logic [15:0]       perf_stall;
`endif

   matvec_mac_sequencer #(.N(N), .DATA_W(DATA_W), .ACC_W(ACC_W), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst(rst), .ld_en(ld_en), .ld_sel(ld_sel), .ld_addr(ld_addr), .ld_data(ld_data),
      .ld_err(ld_err), .start(start), .busy(busy), .done(done), .out_valid(out_valid),
      .out_ready(out_ready), .out_row(out_row), .out_data(out_data)
`ifdef MATVEC_PERF_EN
      , .perf_stall(perf_stall)
`endif
   );

   always #5 clk = ~clk;

   typedef struct { int row; int data; } exp_t;
   typedef int mat_t [16];
   typedef int vec_t [4];

   exp_t sb [$];
   int   checks = 0, errors = 0;
   int   cyc = 0, start_cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Monitor: every cycle with out_valid compares against the scoreboard head; pops on handshake.
   always @(negedge clk) begin
      if (rst === 1'b0 && out_valid === 1'b1) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: row %0d data %0d with empty scoreboard", out_row, out_data);
         end else begin
            check("out_row", 64'(out_row), 64'(sb[0].row));
            check("out_data", 64'(out_data), 64'(sb[0].data));
            if (out_ready === 1'b1) void'(sb.pop_front());
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_rows(input int d0, input int d1, input int d2, input int d3);
      sb.push_back('{0, d0});
      sb.push_back('{1, d1});
      sb.push_back('{2, d2});
      sb.push_back('{3, d3});
   endtask

   task automatic load(input bit sel, input int addr, input int data);
      ld_en   = 1'b1;
      ld_sel  = sel;
      ld_addr = addr[ADDR_W-1:0];
      ld_data = data[DATA_W-1:0];
      tick();
      ld_en   = 1'b0;
   endtask

   task automatic load_all(input mat_t a, input vec_t b);
      for (int i = 0; i < N * N; i++) load(1'b0, i, a[i]);
      for (int i = 0; i < N; i++)     load(1'b1, i, b[i]);
   endtask

   // start_cyc is the index of the edge that samples start.
   task automatic do_start();
      start     = 1'b1;
      start_cyc = cyc + 1;
      tick();
      start     = 1'b0;
   endtask

   // Latency is counted in the cycle numbering where the cycle after edge k is cycle k+1.
   task automatic wait_done(input string name, input int lat, input int stalls);
      bit seen = 1'b0;
      for (int i = 0; i < 200 && !seen; i++) begin
         @(negedge clk);
         if (done === 1'b1) seen = 1'b1;
      end
      if (!seen) check({name, "_timeout"}, 64'd0, 64'd1);
      else begin
         check({name, "_latency"}, 64'(cyc - start_cyc + 1), 64'(lat));
`ifdef MATVEC_PERF_EN
         check({name, "_perf_stall"}, 64'(perf_stall), 64'(stalls));
`else
         if (stalls < 0) $display("negative stall count for %s", name);
`endif
      end
      check({name, "_drain"}, 64'(sb.size()), 64'd0);
      tick();
      check({name, "_idle_after_done"}, 64'({done, busy}), 64'd0);
   endtask

   initial begin
      rst = 1'b1; ld_en = 1'b0; ld_sel = 1'b0; ld_addr = '0; ld_data = '0;
      start = 1'b0; out_ready = 1'b1;
      tick();
      tick();
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_ld_err", 64'(ld_err), 64'd0);
      check("rst_out_row", 64'(out_row), 64'd0);
      check("rst_out_data", 64'(out_data), 64'd0);
      rst = 1'b0;
      tick();

      // Identity A; B[3] is written in the same cycle as start and must be used.
      load_all('{1,0,0,0, 0,1,0,0, 0,0,1,0, 0,0,0,1}, '{1,2,3,0});
      check("valid_load_no_err", 64'(ld_err), 64'd0);
      load(1'b1, 4, 99);
      check("b_addr_range_err", 64'(ld_err), 64'd1);
      tick();
      check("ld_err_single_pulse", 64'(ld_err), 64'd0);
      push_rows(1, 2, 3, 4);
      ld_en = 1'b1; ld_sel = 1'b1; ld_addr = 4'd3; ld_data = 7'd4;
      do_start();
      ld_en = 1'b0;
      check("start_with_load_no_err", 64'(ld_err), 64'd0);
      check("busy_after_start", 64'(busy), 64'd1);
      wait_done("identity", 21, 0);

      // Start and load while busy: both dropped, ld_err pulses.
      push_rows(1, 2, 3, 4);
      do_start();
      tick();
      start = 1'b1; ld_en = 1'b1; ld_sel = 1'b0; ld_addr = 4'd0; ld_data = 7'd9;
      tick();
      start = 1'b0; ld_en = 1'b0;
      check("busy_load_err", 64'(ld_err), 64'd1);
      wait_done("busy_start", 21, 0);
      push_rows(1, 2, 3, 4);
      do_start();
      wait_done("rerun_a0_kept", 21, 0);

      // Full-scale operands: 4*127*127 fits ACC_W.
      load_all('{default: 127}, '{default: 127});
      push_rows(64516, 64516, 64516, 64516);
      do_start();
      wait_done("all127", 21, 0);

      // Back-pressure on row 1 for three cycles.
      load_all('{1,0,0,0, 2,0,0,0, 3,0,0,0, 4,0,0,0}, '{5,5,5,5});
      push_rows(5, 10, 15, 20);
      do_start();
      begin
         bit hit = 1'b0;
         for (int i = 0; i < 100; i++) begin
            if (out_valid === 1'b1 && out_row === 2'd1) begin
               hit = 1'b1;
               break;
            end
            tick();
         end
         if (!hit) check("stall_row1_seen", 64'd0, 64'd1);
      end
      out_ready = 1'b0;
      tick();
      tick();
      tick();
      out_ready = 1'b1;
      wait_done("stall", 24, 3);

      // Reset during row 2 accumulation, then rerun on cleared storage, then reload.
      push_rows(5, 10, 15, 20);
      do_start();
      begin
         bit hit = 1'b0;
         for (int i = 0; i < 100; i++) begin
            if (busy === 1'b1 && out_valid === 1'b0 && out_row === 2'd2) begin
               hit = 1'b1;
               break;
            end
            tick();
         end
         if (!hit) check("row2_mac_seen", 64'd0, 64'd1);
      end
      rst = 1'b1;
      tick();
      check("midrst_busy", 64'(busy), 64'd0);
      check("midrst_out_valid", 64'(out_valid), 64'd0);
      check("midrst_out_row", 64'(out_row), 64'd0);
      check("midrst_out_data", 64'(out_data), 64'd0);
      rst = 1'b0;
      sb.delete();
      tick();
      push_rows(0, 0, 0, 0);
      do_start();
      wait_done("cleared_storage", 21, 0);
      load_all('{1,0,0,0, 0,1,0,0, 0,0,1,0, 0,0,0,1}, '{1,2,3,4});
      push_rows(1, 2, 3, 4);
      do_start();
      wait_done("reload", 21, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
